// File: rtl/noc_pkg.sv
// noc_pkg: shared flit-level constants and types for the NoC arbiter slice
package noc_pkg;
  localparam int FLIT_W = 17;
  localparam int FLIT_VALID_BIT = 16;
  localparam int NUM_PORTS = 5;
  typedef logic [FLIT_W-1:0] flit_t;
endpackage

// File: rtl/flit_fifo_mem.sv
// flit_fifo_mem: DEPTH x FLIT_W register array, synchronous write, asynchronous read
module flit_fifo_mem
  import noc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = noc_pkg::FLIT_W,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  // storage is left unreset; empty-state masking happens in the consumer
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/arb_input_fifo.sv
// arb_input_fifo: per-port ingress FIFO feeding one request/data lane of the round-robin arbiter
module arb_input_fifo
  import noc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int FLIT_W = noc_pkg::FLIT_W,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLIT_W-1:0] in_flit,
  output logic              in_ready,
  output logic              request,
  output logic [FLIT_W-1:0] data,
  input  logic              grant,
  output logic [LW-1:0]     level,
  output logic              err_overflow,
  output logic              err_spurious
);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [FLIT_W-1:0] head;
  logic in_valid, full, push, pop;
  assign in_valid = in_flit[FLIT_W-1];
  assign full = level == LW'(DEPTH);
  assign in_ready = !full;
  assign request = level != '0;
  assign push = in_valid && in_ready;
  assign pop = grant && request;
  assign data = request ? {1'b1, head[FLIT_W-2:0]} : '0;
  flit_fifo_mem #(.DEPTH(DEPTH), .WIDTH(FLIT_W)) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr),
    .wdata(in_flit),
    .raddr(rd_ptr),
    .rdata(head)
  );
  // pointers, occupancy and sticky error flags; all outputs derive from these registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      err_overflow <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(push) - LW'(pop);
      if (in_valid && full) err_overflow <= 1'b1;
      if (grant && !request) err_spurious <= 1'b1;
    end
endmodule

// File: tb/tb_arb_input_fifo.sv
// tb_arb_input_fifo: directed self-checking bench for arb_input_fifo
module tb_arb_input_fifo;
  logic clk = 0, reset = 1, grant = 0;
  logic [16:0] in_flit = '0, data;
  logic in_ready, request, err_overflow, err_spurious;
  logic [2:0] level;
  int checks = 0, errors = 0;

  arb_input_fifo #(.DEPTH(4), .FLIT_W(17)) dut (
    .clk(clk), .reset(reset), .in_flit(in_flit), .in_ready(in_ready),
    .request(request), .data(data), .grant(grant), .level(level),
    .err_overflow(err_overflow), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic [16:0] f, input logic g);
    in_flit = f;
    grant = g;
    @(posedge clk);
    #1;
    in_flit = '0;
    grant = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    #3;
    reset = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (request !== 1'b0) begin errors++; $display("FAIL reset_request got %b exp 0", request); end
    checks++; if (data !== 17'h0) begin errors++; $display("FAIL reset_data got %h exp 0", data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if ({err_overflow, err_spurious} !== 2'b00) begin errors++; $display("FAIL reset_errs got %b exp 00", {err_overflow, err_spurious}); end
  endtask

  task automatic test_push3();
    do_reset();
    cyc(17'h1_0001, 0);
    checks++; if (request !== 1'b1 || data !== 17'h1_0001) begin errors++; $display("FAIL push_latency got req %b data %h exp 1 10001", request, data); end
    cyc(17'h1_0002, 0);
    cyc(17'h1_0003, 0);
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL push3_level got %0d exp 3", level); end
    checks++; if (data !== 17'h1_0001) begin errors++; $display("FAIL push3_data got %h exp 10001", data); end
    checks++; if ({err_overflow, err_spurious} !== 2'b00) begin errors++; $display("FAIL push3_errs got %b exp 00", {err_overflow, err_spurious}); end
    cyc(17'h0, 1);
    checks++; if (data !== 17'h1_0002) begin errors++; $display("FAIL pop1_data got %h exp 10002", data); end
    cyc(17'h0, 1);
    checks++; if (data !== 17'h1_0003) begin errors++; $display("FAIL pop2_data got %h exp 10003", data); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) cyc(17'h1_00A0 + 17'(i), 0);
    checks++; if (in_ready !== 1'b0 || level !== 3'd4) begin errors++; $display("FAIL full got in_ready %b level %0d exp 0 4", in_ready, level); end
    cyc(17'h1_00FF, 0);
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d exp 4", level); end
    checks++; if (err_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", err_overflow); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (data !== 17'h1_00A0 + 17'(i)) begin errors++; $display("FAIL drain_%0d got %h exp %h", i, data, 17'h1_00A0 + 17'(i)); end
      cyc(17'h0, 1);
    end
    checks++; if (request !== 1'b0 || data !== 17'h0) begin errors++; $display("FAIL drain_empty got req %b data %h exp 0 0", request, data); end
    checks++; if (err_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", err_overflow); end
  endtask

  task automatic test_no_bypass();
    do_reset();
    for (int i = 0; i < 4; i++) cyc(17'h1_00D0 + 17'(i), 0);
    cyc(17'h1_00EE, 1);
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL nobypass_level got %0d exp 3", level); end
    checks++; if (data !== 17'h1_00D1) begin errors++; $display("FAIL nobypass_head got %h exp 100d1", data); end
    cyc(17'h0, 1); cyc(17'h0, 1);
    checks++; if (data !== 17'h1_00D3) begin errors++; $display("FAIL nobypass_tail got %h exp 100d3", data); end
  endtask

  task automatic test_back_to_back();
    logic [16:0] exp;
    do_reset();
    cyc(17'h1_00B0, 0);
    cyc(17'h1_00B1, 0);
    cyc(17'h1_00B2, 1);
    checks++; if (level !== 3'd2 || data !== 17'h1_00B1) begin errors++; $display("FAIL simul got level %0d data %h exp 2 100b1", level, data); end
    for (int i = 0; i < 8; i++) begin
      cyc(17'h1_00C0 + 17'(i), 1);
      exp = (i == 0) ? 17'h1_00B2 : 17'h1_00C0 + 17'(i - 1);
      checks++; if (level !== 3'd2 || data !== exp) begin errors++; $display("FAIL wrap_%0d got level %0d data %h exp 2 %h", i, level, data, exp); end
    end
  endtask

  task automatic test_spurious();
    do_reset();
    cyc(17'h0, 1);
    checks++; if (err_spurious !== 1'b1) begin errors++; $display("FAIL spur_flag got %b exp 1", err_spurious); end
    checks++; if (level !== 3'd0 || request !== 1'b0) begin errors++; $display("FAIL spur_level got level %0d req %b exp 0 0", level, request); end
    cyc(17'h1_1234, 0);
    checks++; if (data !== 17'h1_1234 || level !== 3'd1) begin errors++; $display("FAIL spur_push got data %h level %0d exp 11234 1", data, level); end
    checks++; if (err_spurious !== 1'b1 || err_overflow !== 1'b0) begin errors++; $display("FAIL spur_sticky got %b%b exp 10", err_spurious, err_overflow); end
  endtask

  task automatic test_invalid();
    do_reset();
    cyc(17'h0_BEEF, 0);
    checks++; if (level !== 3'd0 || request !== 1'b0 || data !== 17'h0) begin errors++; $display("FAIL invalid_empty got level %0d req %b data %h exp 0 0 0", level, request, data); end
    cyc(17'h1_0005, 0);
    cyc(17'h0_BEEF, 0);
    checks++; if (level !== 3'd1 || data !== 17'h1_0005) begin errors++; $display("FAIL invalid_nonempty got level %0d data %h exp 1 10005", level, data); end
  endtask

  task automatic test_async_reset();
    do_reset();
    cyc(17'h0, 1);
    for (int i = 0; i < 5; i++) cyc(17'h1_0010 + 17'(i), 0);
    cyc(17'h0, 1);
    checks++; if (level !== 3'd3 || {err_overflow, err_spurious} !== 2'b11) begin errors++; $display("FAIL pre_reset got level %0d errs %b exp 3 11", level, {err_overflow, err_spurious}); end
    #2;
    reset = 1;
    #1;
    checks++; if (level !== 3'd0 || request !== 1'b0 || data !== 17'h0 || in_ready !== 1'b1) begin errors++; $display("FAIL async_reset got level %0d req %b data %h rdy %b exp 0 0 0 1", level, request, data, in_ready); end
    checks++; if ({err_overflow, err_spurious} !== 2'b00) begin errors++; $display("FAIL async_errs got %b exp 00", {err_overflow, err_spurious}); end
    #1;
    reset = 0;
    cyc(17'h1_0777, 0);
    checks++; if (data !== 17'h1_0777 || level !== 3'd1) begin errors++; $display("FAIL post_reset got data %h level %0d exp 10777 1", data, level); end
  endtask

  initial begin
    test_reset();
    test_push3();
    test_overflow();
    test_no_bypass();
    test_back_to_back();
    test_spurious();
    test_invalid();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
